fmad_arbiter: RTL

//  Shares one fmad unit between NREQ requesters. Round-robin grant; one op in flight.

---
 rtl/fmad_arbiter_if.sv | 44 ++++
 rtl/fmad_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fmad_arbiter_if.sv
// Signal bundle between fmad_arbiter, its requesters, the result consumer and the fmad unit.
// Every valid/ready pair transfers on a cycle where both are high at the rising clock edge.
interface fmad_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       reqValid;
    logic [NREQ-1:0]       reqReady;
    logic [NREQ*WIDTH-1:0] reqMulIn1;
    logic [NREQ*WIDTH-1:0] reqMulIn2;
    logic [NREQ*WIDTH-1:0] reqAddIn;
    logic [NREQ-1:0]       reqSub;
    logic [NREQ-1:0]       reqNegate;
    logic                  respValid;
    logic                  respReady;
    logic [IDW-1:0]        respId;
    logic [2*WIDTH-1:0]    respData;
    logic                  respErr;
    logic                  busy;
    logic                  start;
    logic [WIDTH-1:0]      fmadMulIn1;
    logic [WIDTH-1:0]      fmadMulIn2;
    logic [WIDTH-1:0]      fmadAddIn;
    logic                  sub;
    logic                  negate;
    logic [2*WIDTH-1:0]    fmadOut;
    logic                  fmadDone;

    modport slave (
        input  reqValid, reqMulIn1, reqMulIn2, reqAddIn, reqSub, reqNegate,
        input  respReady, fmadOut, fmadDone,
        output reqReady, respValid, respId, respData, respErr, busy,
        output start, fmadMulIn1, fmadMulIn2, fmadAddIn, sub, negate
    );

    modport master (
        output reqValid, reqMulIn1, reqMulIn2, reqAddIn, reqSub, reqNegate,
        output respReady, fmadOut, fmadDone,
        input  reqReady, respValid, respId, respData, respErr, busy,
        input  start, fmadMulIn1, fmadMulIn2, fmadAddIn, sub, negate
    );
endinterface

// File: rtl/fmad_arbiter.sv
// Round-robin arbiter sharing one fmad unit among NREQ requesters, one op in flight,
// with a watchdog that turns a missing fmadDone into an error response.
module fmad_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    fmad_arbiter_if.slave bus,
    output logic [1:0]    fsm_state
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     cur_id;
    logic [TW-1:0]      timer;
    logic               start_r;
    logic [WIDTH-1:0]   mul1_r;
    logic [WIDTH-1:0]   mul2_r;
    logic [WIDTH-1:0]   add_r;
    logic               sub_r;
    logic               neg_r;
    logic               resp_valid_r;
    logic [IDW-1:0]     resp_id_r;
    logic [2*WIDTH-1:0] resp_data_r;
    logic               resp_err_r;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic [NREQ-1:0]    ready_vec;

    // Search starts just above the last winner so it has lowest priority next time.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && bus.reqValid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (!reset && state == IDLE && grant_found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= IDW'(NREQ - 1);
            cur_id       <= '0;
            timer        <= '0;
            start_r      <= 1'b0;
            mul1_r       <= '0;
            mul2_r       <= '0;
            add_r        <= '0;
            sub_r        <= 1'b0;
            neg_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            start_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state   <= ISSUE;
                        start_r <= 1'b1;
                        cur_id  <= grant_idx;
                        mul1_r  <= bus.reqMulIn1[int'(grant_idx)*WIDTH +: WIDTH];
                        mul2_r  <= bus.reqMulIn2[int'(grant_idx)*WIDTH +: WIDTH];
                        add_r   <= bus.reqAddIn[int'(grant_idx)*WIDTH +: WIDTH];
                        sub_r   <= bus.reqSub[grant_idx];
                        neg_r   <= bus.reqNegate[grant_idx];
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // Done is tested first so a result arriving on the last cycle still counts.
                    if (bus.fmadDone) begin
                        resp_data_r  <= bus.fmadOut;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_id_r    <= cur_id;
                        state        <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        resp_data_r  <= '0;
                        resp_err_r   <= 1'b1;
                        resp_valid_r <= 1'b1;
                        resp_id_r    <= cur_id;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.respReady) begin
                        resp_valid_r <= 1'b0;
                        last_grant   <= cur_id;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.reqReady   = ready_vec;
    assign bus.respValid  = resp_valid_r;
    assign bus.respId     = resp_id_r;
    assign bus.respData   = resp_data_r;
    assign bus.respErr    = resp_err_r;
    assign bus.busy       = (state != IDLE);
    assign bus.start      = start_r;
    assign bus.fmadMulIn1 = mul1_r;
    assign bus.fmadMulIn2 = mul2_r;
    assign bus.fmadAddIn  = add_r;
    assign bus.sub        = sub_r;
    assign bus.negate     = neg_r;
    assign fsm_state      = state;
endmodule
